// File: rtl/key_event_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : key_event_pkg
//  Description : Shared keycode constants and debounce state encoding for the
//                key event conditioning front end.
//  Revision    : 1.0 - initial release
// ============================================================================
package key_event_pkg;

    // USB HID keycodes used by the game consumers
    localparam logic [7:0] KEY_NONE  = 8'd0;
    localparam logic [7:0] KEY_UP    = 8'd82;
    localparam logic [7:0] KEY_DOWN  = 8'd81;
    localparam logic [7:0] KEY_LEFT  = 8'd80;
    localparam logic [7:0] KEY_RIGHT = 8'd79;
    localparam logic [7:0] KEY_Z     = 8'd29;
    localparam logic [7:0] KEY_X     = 8'd27;
    localparam logic [7:0] KEY_SPACE = 8'd44;

    // Debounce qualifier states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CAND = 2'd1,
        HELD = 2'd2
    } deb_state_e;

endpackage
`default_nettype wire

// File: rtl/key_event_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : key_event_fifo
//  Description : Small ready/valid event FIFO with registered head outputs.
//                Write/read strobes arrive pre-qualified from the producer;
//                a dropped event is reported through i_drop and latched into
//                a sticky overflow flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module key_event_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             i_wr,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_rd,
    input  logic             i_drop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic             o_overflow
);

    localparam int            AW      = $clog2(DEPTH);
    localparam logic [AW:0]   c_DEPTH = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic [WIDTH-1:0] r_head;
    logic             r_valid;
    logic             r_ovf;

    logic [AW:0]      w_count_nxt;
    logic [AW:0]      w_fill;
    logic [AW-1:0]    w_rptr_nxt;
    logic [WIDTH-1:0] w_head_nxt;

    // Next occupancy / head: the head register is preloaded so that the
    // outputs are registered; a write into an otherwise-empty queue becomes
    // the head one cycle later (no bypass).
    always_comb begin
        w_count_nxt = r_count + (AW+1)'(i_wr) - (AW+1)'(i_rd);
        w_fill      = r_count - (AW+1)'(i_rd);
        w_rptr_nxt  = r_rptr + AW'(i_rd);
        w_head_nxt  = '0;
        if (w_count_nxt != '0) begin
            if (w_fill == '0) begin
                w_head_nxt = i_data;
            end else begin
                w_head_nxt = r_mem[w_rptr_nxt];
            end
        end
    end

    // Storage array write port
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_wr) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    // Pointers, occupancy, registered head and sticky overflow
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_head  <= '0;
            r_valid <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_wptr  <= r_wptr + AW'(i_wr);
            r_rptr  <= w_rptr_nxt;
            r_count <= w_count_nxt;
            r_head  <= w_head_nxt;
            r_valid <= (w_count_nxt != '0);
            if (i_drop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign o_data     = r_head;
    assign o_empty    = ~r_valid;
    assign o_full     = (r_count == c_DEPTH);
    assign o_overflow = r_ovf;

endmodule
`default_nettype wire

// File: rtl/key_event_queue.sv
`default_nettype none
// ============================================================================
//  Module      : key_event_queue
//  Description : Keyboard front end. Synchronises the raw frame clock into a
//                one-cycle tick, debounces the registered keycode over a
//                number of frame ticks and queues one event per qualified
//                press. Held keys never repeat.
//  Revision    : 1.0 - initial release
// ============================================================================
module key_event_queue
    import key_event_pkg::*;
#(
    parameter int DEPTH         = 4,
    parameter int STABLE_FRAMES = 2
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_clk,
    input  logic [7:0] keycode,
    input  logic       ev_ready,
    output logic       ev_valid,
    output logic [7:0] ev_keycode,
    output logic       game_frame_clk_rising_edge,
    output logic       overflow
);

    localparam int               CNT_W      = $clog2(STABLE_FRAMES) + 1;
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(STABLE_FRAMES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_sync3;
    logic             r_tick;
    logic [7:0]       r_key_s;

    deb_state_e       r_state;
    logic [7:0]       r_cand;
    logic [CNT_W-1:0] r_cnt;

    deb_state_e       w_state_nxt;
    logic [7:0]       w_cand_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_push;

    logic             w_full;
    logic             w_empty;
    logic             w_rd;
    logic             w_wr;
    logic             w_drop;

    // Two-flop synchroniser plus registered rising-edge detect of frame_clk
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
            r_tick  <= 1'b0;
        end else begin
            r_sync1 <= frame_clk;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
            r_tick  <= r_sync2 & ~r_sync3;
        end
    end

    // Register the raw keycode; the qualifier only ever looks at this copy
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_key_s <= KEY_NONE;
        end else begin
            r_key_s <= keycode;
        end
    end

    // Debounce next-state: a keycode change outranks a tick in the same
    // cycle, and the cycle that enters CAND never counts a tick.
    always_comb begin
        w_state_nxt = r_state;
        w_cand_nxt  = r_cand;
        w_cnt_nxt   = r_cnt;
        w_push      = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_key_s != KEY_NONE) begin
                    w_state_nxt = CAND;
                    w_cand_nxt  = r_key_s;
                    w_cnt_nxt   = '0;
                end
            end
            CAND: begin
                if (r_key_s != r_cand) begin
                    if (r_key_s == KEY_NONE) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_cand_nxt = r_key_s;
                        w_cnt_nxt  = '0;
                    end
                end else if (r_tick) begin
                    if (r_cnt == c_CNT_LAST) begin
                        w_push      = 1'b1;
                        w_state_nxt = HELD;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end
            HELD: begin
                if (r_key_s == KEY_NONE) begin
                    w_state_nxt = IDLE;
                end else if (r_key_s != r_cand) begin
                    w_state_nxt = CAND;
                    w_cand_nxt  = r_key_s;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Debounce state registers
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= IDLE;
            r_cand  <= KEY_NONE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cand  <= w_cand_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Queue arbitration: a pop frees a slot for a simultaneous push when
    // full; ready while empty is ignored.
    assign w_rd   = ev_ready & ~w_empty;
    assign w_wr   = w_push & (~w_full | w_rd);
    assign w_drop = w_push & w_full & ~w_rd;

    key_event_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .i_wr       (w_wr),
        .i_data     (r_cand),
        .i_rd       (w_rd),
        .i_drop     (w_drop),
        .o_data     (ev_keycode),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_overflow (overflow)
    );

    assign ev_valid                   = ~w_empty;
    assign game_frame_clk_rising_edge = r_tick;

endmodule
`default_nettype wire

// File: tb/tb_key_event_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_key_event_queue
//  Description : Self-checking bench for key_event_queue against a run-length
//                reference model of the debounce rule and a queue model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_key_event_queue;

    localparam int DEPTH = 4;
    localparam int SF    = 2;

    logic       Clk       = 1'b0;
    logic       Reset_n   = 1'b0;
    logic       frame_clk = 1'b0;
    logic [7:0] keycode   = 8'd0;
    logic       ev_ready  = 1'b0;
    logic       ev_valid;
    logic [7:0] ev_keycode;
    logic       tick;
    logic       overflow;

    always #5 Clk = ~Clk;

    key_event_queue #(
        .DEPTH         (DEPTH),
        .STABLE_FRAMES (SF)
    ) dut (
        .Clk                        (Clk),
        .Reset_n                    (Reset_n),
        .frame_clk                  (frame_clk),
        .keycode                    (keycode),
        .ev_ready                   (ev_ready),
        .ev_valid                   (ev_valid),
        .ev_keycode                 (ev_keycode),
        .game_frame_clk_rising_edge (tick),
        .overflow                   (overflow)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // A press is a run of identical nonzero registered keycodes. Frame ticks
    // seen after the first cycle of the run are counted; the run yields one
    // event when the count reaches SF.
    int       m_q[$];
    bit       m_ovf;
    bit [7:0] m_key_s, m_prev;
    bit       m_tick;
    bit       fc1, fc2, fc3;
    int       m_cnt;
    bit       m_done, m_push, m_full, m_pop;

    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            m_q.delete();
            m_ovf = 0; m_key_s = 0; m_prev = 0; m_tick = 0;
            fc1 = 0; fc2 = 0; fc3 = 0; m_cnt = 0; m_done = 0;
        end else begin
            m_push = 0;
            if (m_key_s != m_prev) begin
                m_cnt = 0;
                m_done = 0;
            end else if (m_key_s != 0 && m_tick && !m_done) begin
                m_cnt++;
                if (m_cnt == SF) begin
                    m_push = 1;
                    m_done = 1;
                end
            end
            m_full = (m_q.size() == DEPTH);
            m_pop  = (m_q.size() != 0) && ev_ready;
            if (m_pop) void'(m_q.pop_front());
            if (m_push) begin
                if (!m_full || m_pop) m_q.push_back(int'(m_key_s));
                else m_ovf = 1;
            end
            m_prev  = m_key_s;
            m_key_s = keycode;
            // frame_clk sampled three edges ago high, four edges ago low
            m_tick  = fc2 & ~fc3;
            fc3 = fc2; fc2 = fc1; fc1 = frame_clk;
        end
    end

    // Compare every cycle, away from the active edge
    always @(negedge Clk) begin
        if (Reset_n) begin
            check("valid",    ev_valid,   m_q.size() != 0);
            check("keycode",  ev_keycode, (m_q.size() != 0) ? m_q[0] : 0);
            check("overflow", overflow,   m_ovf);
            check("tick",     tick,       m_tick);
        end
    end

    // ---------------- stimulus ----------------
    bit rnd_ready = 0;
    int ready_pct = 50;

    // Frame clock: free-running, toggles every 3..5 cycles
    initial begin
        forever begin
            repeat ($urandom_range(3, 5)) @(negedge Clk);
            frame_clk = ~frame_clk;
        end
    end

    task automatic hold(input logic [7:0] k, input int cycles);
        keycode = k;
        for (int i = 0; i < cycles; i++) begin
            if (rnd_ready) ev_ready = ($urandom_range(0, 99) < ready_pct);
            @(negedge Clk);
        end
    endtask

    // Reset pulse strictly between edges; outputs must clear without a clock
    task automatic pulse_reset();
        @(posedge Clk);
        #2 Reset_n = 1'b0;
        #1;
        check("rst_valid",    ev_valid,   0);
        check("rst_keycode",  ev_keycode, 0);
        check("rst_overflow", overflow,   0);
        check("rst_tick",     tick,       0);
        #1 Reset_n = 1'b1;
        @(negedge Clk);
    endtask

    initial begin
        logic [7:0] keys [7];
        keys = '{8'd82, 8'd81, 8'd80, 8'd79, 8'd29, 8'd27, 8'd44};

        repeat (3) @(negedge Clk);
        check("init_valid",    ev_valid,   0);
        check("init_keycode",  ev_keycode, 0);
        check("init_overflow", overflow,   0);
        Reset_n = 1'b1;

        // single press, consumer always ready
        ev_ready = 1'b1;
        hold(8'd82, 45); hold(8'd0, 20);

        // glitch rejection, then a direct key-to-key change
        hold(8'd81, 8); hold(8'd0, 20);
        hold(8'd81, 5); hold(8'd80, 30); hold(8'd0, 10);

        // ordered sequence with the consumer stalled, then drained
        ev_ready = 1'b0;
        hold(8'd82, 30); hold(8'd0, 5); hold(8'd82, 30);
        hold(8'd81, 30); hold(8'd0, 5); hold(8'd81, 30); hold(8'd0, 10);
        ev_ready = 1'b1;
        hold(8'd0, 10);

        // overflow: five keys into a four-entry queue
        pulse_reset();
        ev_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            hold((i < 4) ? keys[3 - i] : 8'd44, 30);
            hold(8'd0, 5);
        end
        ev_ready = 1'b1;
        hold(8'd0, 10);

        // asynchronous reset with events queued and a key mid-qualification
        pulse_reset();
        ev_ready = 1'b0;
        hold(8'd29, 30); hold(8'd0, 5); hold(8'd27, 30); hold(8'd0, 5);
        hold(8'd44, 10);
        pulse_reset();
        hold(8'd44, 40); hold(8'd0, 5);
        ev_ready = 1'b1;
        hold(8'd0, 10);

        // randomized presses with varying consumer back-pressure
        rnd_ready = 1;
        for (int blk = 0; blk < 6; blk++) begin
            pulse_reset();
            ready_pct = (blk % 3 == 0) ? 5 : ((blk % 3 == 1) ? 30 : 90);
            for (int p = 0; p < 60; p++) begin
                logic [7:0] k;
                k = ($urandom_range(0, 7) == 7) ? 8'($urandom_range(1, 255))
                                                 : keys[$urandom_range(0, 6)];
                hold(k, $urandom_range(1, 40));
                if ($urandom_range(0, 1) == 1) hold(8'd0, $urandom_range(1, 10));
            end
        end
        rnd_ready = 0;
        ev_ready  = 1'b1;
        hold(8'd0, 20);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/key_event_queue.md
# key_event_queue

Front-end conditioning stage between the USB keyboard keycode register and the keycode consumers: the cheat-code FSM, player control and menus. It registers the raw 8-bit keycode and synchronises the raw frame clock into a one-cycle `game_frame_clk_rising_edge` tick. It qualifies a key press only after the key is stable for a configurable number of frame ticks, and queues each qualified press as a single event in a small ready/valid FIFO. Held keys produce exactly one event, so downstream sequence detectors never see a held key as repeated input.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; power of two, at least 2.
- `STABLE_FRAMES`, 2: frame ticks a keycode must stay unchanged before it is accepted; at least 1.

Ports:
- `Clk` in 1: system clock.
- `Reset_n` in 1: reset, asynchronous, active-low.
- `frame_clk` in 1: raw frame clock (VGA vsync), asynchronous to `Clk`.
- `keycode` in 8: raw keycode from USB; 0 means no key.
- `ev_ready` in 1: consumer accepts the head event.
- `ev_valid` out 1: FIFO not empty.
- `ev_keycode` out 8: head event keycode.
- `game_frame_clk_rising_edge` out 1: one-cycle tick per `frame_clk` rising edge.
- `overflow` out 1: sticky; set when an event is dropped.

## Operation
- **Reset.** While `Reset_n`=0, all outputs and all state are 0: FSM in IDLE, FIFO empty, `ev_keycode`=0.
- **Frame tick.**
  - `frame_clk` passes through a 2-flop synchroniser, then a registered edge detect.
  - `game_frame_clk_rising_edge` = sync2 & ~sync3, registered. It is high for exactly 1 cycle per rising edge.
  - The internal `tick` used by the FSM is the same registered signal.
- **Keycode sampling.** `key_s` <= `keycode` every cycle. The FSM uses only `key_s`.
- **Debounce FSM.** Registers are `cand` (8 bits) and `cnt` (clog2(STABLE_FRAMES)+1 bits).
  - IDLE, `key_s`=0: stay in IDLE.
  - IDLE, `key_s`!=0: go to CAND; `cand`<=`key_s`, `cnt`<=0.
  - CAND, `key_s`!=`cand`:
    - if `key_s`=0, go to IDLE;
    - otherwise stay in CAND with `cand`<=`key_s`, `cnt`<=0.
  - A key change takes priority over a tick in the same cycle.
  - CAND, `key_s`=`cand`, `tick`=1:
    - if `cnt`=STABLE_FRAMES-1, raise `push`, go to HELD;
    - otherwise `cnt`++.
  - Ticks are counted only in cycles where the state is already CAND; the entry cycle does not count.
  - HELD, `key_s`=`cand`: stay in HELD; no repeat events.
  - HELD, `key_s`=0: go to IDLE.
  - HELD, other nonzero `key_s`: go to CAND with the new `cand`, `cnt`<=0.
- **FIFO.**
  - `push` writes `cand`.
  - A pop happens when `ev_valid` & `ev_ready`.
  - `ev_keycode` = head entry; it is 0 when empty.
  - Occupancy counter is clog2(DEPTH)+1 bits; read and write pointers are clog2(DEPTH) bits and wrap modulo DEPTH.
- **Boundaries.**
  - Push while full with no pop: the event is dropped, `overflow`<=1, and it stays 1 until reset. FIFO contents are unchanged.
  - Push and pop in the same cycle while full: both happen, no drop, occupancy unchanged.
  - Push and pop in the same cycle while empty: only the push happens; the event becomes visible next cycle (no bypass).
  - `ev_ready` while empty: ignored.
- **Reset mid-operation.** Asserting `Reset_n`=0 discards queued events and any in-progress qualification immediately, without waiting for a clock edge.

## Timing
- `frame_clk` rise to `game_frame_clk_rising_edge`: 3–4 `Clk` cycles.
- `keycode` change to `key_s`: 1 cycle. `key_s` to state change: 1 cycle.
- The qualifying tick cycle raises `push`. The FIFO write lands at the next edge, and `ev_valid`=1 from that cycle on.
- Minimum press-to-event latency: 2 cycles plus STABLE_FRAMES ticks.
- `ev_valid` and `ev_keycode` are registered outputs. They hold steady while `ev_ready`=0. After a pop they show the next entry on the following cycle.

## Structure
- **Package `key_event_pkg`** holds:
  - keycode constants: `KEY_NONE`=0, `KEY_UP`=82, `KEY_DOWN`=81, `KEY_LEFT`=80, `KEY_RIGHT`=79, `KEY_Z`=29, `KEY_X`=27, `KEY_SPACE`=44;
  - the debounce state enum {IDLE, CAND, HELD}.
- **Sub-module `key_event_fifo`**: parameterised by `DEPTH` and width. It has push/pop/data ports plus full/empty and `overflow`, and uses the same `Clk`/`Reset_n`.
- The top level holds the synchroniser, the edge detect and the debounce FSM.

## Test plan
- **Single press.** STABLE_FRAMES=2, `ev_ready`=1. Hold `keycode`=82 across 5 ticks, then release to 0. Expect exactly one event, 82, with `ev_valid` high for 1 cycle starting the cycle after the 2nd counted tick.
- **Glitch rejection.** Set `keycode`=81 for 1 tick, then 0. Expect no event. Then 81→80 with no zero in between, 80 stable 2 ticks. Expect one event, 80.
- **Ordered sequence.** Hold `ev_ready`=0. Send 82, 82 (with a release to 0 between), 81, 81, each held 3 ticks. Expect the FIFO to hold 4 entries. Then raise `ev_ready`: expect pops in order 82, 82, 81, 81 on consecutive cycles; then `ev_valid`=0.
- **Overflow.** DEPTH=4, `ev_ready`=0. Queue 5 distinct keys: 79, 80, 81, 82, 44. Expect `overflow`=1 after the 5th key, contents 79..82, and 44 lost. Raise `ev_ready`: expect `overflow` still 1.
- **Full push and pop together.** With the FIFO full, apply a pop in the same cycle the 5th key qualifies. Expect no drop, `overflow`=0, and order preserved: 80, 81, 82, 44.
- **Asynchronous reset.** With 2 events queued and a key in CAND, pulse `Reset_n` low between clock edges. Expect `ev_valid`=0, `overflow`=0, `ev_keycode`=0 immediately. A held key then takes the full STABLE_FRAMES ticks to re-qualify.
